// File: rtl/fpga_bus_master_pkg.sv
// Shared types and constants for the FPGA register bus initiator:
// FSM states, 68040 SIZ codes, register indices and the write-lane helper.
package fpga_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_TERM   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SIZ_LONG = 2'b00,
        SIZ_BYTE = 2'b01,
        SIZ_WORD = 2'b10,
        SIZ_LINE = 2'b11
    } siz_e;

    localparam logic [3:0] REG_INT = 4'h4;

    // Big-endian lane index of the write byte: 0 = D31:24 ... 3 = D7:0.
    function automatic logic [1:0] lane_sel(input siz_e siz, input logic [1:0] addr_lo);
        logic [1:0] lane;
        case (siz)
            SIZ_BYTE: lane = addr_lo;
            SIZ_WORD: lane = addr_lo[1] ? 2'd3 : 2'd1;
            default:  lane = 2'd3;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/fpga_bus_master_if.sv
// CPU-pin and FPGA-register-bus signals of the initiator, grouped as one bundle.
// master = the initiator block, slave = the CPU pins plus register responders.
interface fpga_bus_master_if;

    logic        cpu_ts_n;
    logic        cpu_sel;
    logic        cpu_rw;
    logic [1:0]  cpu_siz;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_dout;
    logic [31:0] cpu_din;
    logic        cpu_d_oe;
    logic        cpu_ta_n;
    logic        cpu_tea_n;

    logic        fpga_stb;
    logic        fpga_we;
    logic [3:0]  fpga_addr;
    logic [7:0]  fpga_data;
    logic        fpga_ack;
    logic [31:0] fpga_odata;

    modport master (
        input  cpu_ts_n, cpu_sel, cpu_rw, cpu_siz, cpu_addr, cpu_dout,
        output cpu_din, cpu_d_oe, cpu_ta_n, cpu_tea_n,
        output fpga_stb, fpga_we, fpga_addr, fpga_data,
        input  fpga_ack, fpga_odata
    );

    modport slave (
        output cpu_ts_n, cpu_sel, cpu_rw, cpu_siz, cpu_addr, cpu_dout,
        input  cpu_din, cpu_d_oe, cpu_ta_n, cpu_tea_n,
        input  fpga_stb, fpga_we, fpga_addr, fpga_data,
        output fpga_ack, fpga_odata
    );

endinterface

// File: rtl/fpga_wr_lane_mux.sv
// Selects the single write byte carried on the big-endian 68040 data bus
// for the latched transfer size and low address bits.
module fpga_wr_lane_mux
    import fpga_bus_master_pkg::*;
(
    input  siz_e        siz_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] dout_i,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = dout_i[7:0];
        case (lane_sel(siz_i, addr_lo_i))
            2'd0:    byte_o = dout_i[31:24];
            2'd1:    byte_o = dout_i[23:16];
            2'd2:    byte_o = dout_i[15:8];
            default: byte_o = dout_i[7:0];
        endcase
    end

endmodule

// File: rtl/fpga_bus_master.sv
// 68040 FPGA-window initiator: turns one CPU bus cycle into a single fpga_stb/ack
// transaction and ends it with TA_n, or TEA_n when the responder never acks.
module fpga_bus_master
    import fpga_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMO_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    fpga_bus_master_if.master  bus
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

    state_e           state_q, state_d;
    logic             rw_q, rw_d;
    siz_e             siz_q, siz_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] cnt_inc;

    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [3:0]       faddr_q, faddr_d;
    logic [7:0]       fdata_q, fdata_d;
    logic [31:0]      din_q, din_d;
    logic             doe_q, doe_d;
    logic             ta_n_q, ta_n_d;
    logic             tea_n_q, tea_n_d;

    logic [7:0]       wr_byte;

    fpga_wr_lane_mux u_lane_mux (
        .siz_i     (siz_q),
        .addr_lo_i (addr_lo_q),
        .dout_i    (bus.cpu_dout),
        .byte_o    (wr_byte)
    );

    assign cnt_inc = cnt_q + TMO_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d   = state_q;
        rw_d      = rw_q;
        siz_d     = siz_q;
        addr_lo_d = addr_lo_q;
        cnt_d     = cnt_q;
        stb_d     = 1'b0;
        we_d      = we_q;
        faddr_d   = faddr_q;
        fdata_d   = fdata_q;
        din_d     = din_q;
        doe_d     = 1'b0;
        ta_n_d    = 1'b1;
        tea_n_d   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                we_d  = 1'b0;
                if (!bus.cpu_ts_n && bus.cpu_sel) begin
                    rw_d      = bus.cpu_rw;
                    siz_d     = siz_e'(bus.cpu_siz);
                    addr_lo_d = bus.cpu_addr[1:0];
                    faddr_d   = bus.cpu_addr[5:2];
                    state_d   = ST_LATCH;
                end
            end

            // Write data appears on the pins one cycle after TS.
            ST_LATCH: begin
                fdata_d = rw_q ? 8'h00 : wr_byte;
                we_d    = !rw_q;
                stb_d   = 1'b1;
                state_d = ST_STROBE;
            end

            // A level ack here may still be left over from the previous cycle.
            ST_STROBE: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (bus.fpga_ack) begin
                    if (rw_q) begin
                        din_d = bus.fpga_odata;
                    end
                    ta_n_d  = 1'b0;
                    doe_d   = rw_q;
                    state_d = ST_TERM;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_inc;
                    end
                    if (TMO_EN && (cnt_inc == TMO_LIMIT)) begin
                        din_d   = '0;
                        tea_n_d = 1'b0;
                        doe_d   = rw_q;
                        state_d = ST_TERM;
                    end
                end
            end

            ST_TERM: begin
                cnt_d   = '0;
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin outputs are registered from next-state values: aligned with the state, glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q      <= 1'b0;
            siz_q     <= SIZ_LONG;
            addr_lo_q <= 2'b00;
            cnt_q     <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            faddr_q   <= 4'h0;
            fdata_q   <= 8'h00;
            din_q     <= 32'h0;
            doe_q     <= 1'b0;
            ta_n_q    <= 1'b1;
            tea_n_q   <= 1'b1;
        end else begin
            rw_q      <= rw_d;
            siz_q     <= siz_d;
            addr_lo_q <= addr_lo_d;
            cnt_q     <= cnt_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            faddr_q   <= faddr_d;
            fdata_q   <= fdata_d;
            din_q     <= din_d;
            doe_q     <= doe_d;
            ta_n_q    <= ta_n_d;
            tea_n_q   <= tea_n_d;
        end
    end

    assign bus.fpga_stb  = stb_q;
    assign bus.fpga_we   = we_q;
    assign bus.fpga_addr = faddr_q;
    assign bus.fpga_data = fdata_q;
    assign bus.cpu_din   = din_q;
    assign bus.cpu_d_oe  = doe_q;
    assign bus.cpu_ta_n  = ta_n_q;
    assign bus.cpu_tea_n = tea_n_q;

endmodule
